// File: rtl/ram_datos_dump_ctrl_pkg.sv
// Shared types and constants for the data RAM dump controller.
// Holds the controller/serializer state encodings and default widths.
package ram_datos_dump_ctrl_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int DATA_W_DEF     = 16;
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_XFER,
    ST_NEXT,
    ST_DONE
  } ctrl_st_t;

  typedef enum logic [3:0] {
    SR_IDLE,
    SR_SEND_HI,
    SR_WAIT_HI,
    SR_SEND_LO,
    SR_WAIT_LO
  } ser_st_t;

endpackage

// File: rtl/ram_datos_dump_ctrl_if.sv
// RAM port and UART TX handshake bundle of the dump controller.
// master: controller side; slave: reg_file + UART side.
interface ram_datos_dump_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done;

  modport master (
    output mem_wr_en, mem_w_addr, mem_r_addr,
    output mem_w_data, tx_data, tx_start,
    input  mem_r_data, tx_done
  );

  modport slave (
    input  mem_wr_en, mem_w_addr, mem_r_addr,
    input  mem_w_data, tx_data, tx_start,
    output mem_r_data, tx_done
  );
endinterface

// File: rtl/ram_datos_dump_ctrl_ser.sv
// Sends one 16-bit word as two UART bytes, high byte first.
// Ports: go starts a word, word_sent pulses after the low byte's tx_done.
module ram_datos_dump_ctrl_ser
  import ram_datos_dump_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [15:0] word,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        word_sent
);

  ser_st_t st, st_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= SR_IDLE;
    else        st <= st_nx;
  end

  // tx_done only matters in the WAIT states, so a
  // done coinciding with tx_start is ignored.
  always_comb begin
    st_nx     = st;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    word_sent = 1'b0;
    unique case (st)
      SR_IDLE: begin
        if (go) st_nx = SR_SEND_HI;
      end
      SR_SEND_HI: begin
        tx_start = 1'b1;
        tx_data  = word[15:8];
        st_nx    = SR_WAIT_HI;
      end
      SR_WAIT_HI: begin
        tx_data = word[15:8];
        if (tx_done) st_nx = SR_SEND_LO;
      end
      SR_SEND_LO: begin
        tx_start = 1'b1;
        tx_data  = word[7:0];
        st_nx    = SR_WAIT_LO;
      end
      SR_WAIT_LO: begin
        tx_data = word[7:0];
        if (tx_done) begin
          word_sent = 1'b1;
          st_nx     = SR_IDLE;
        end
      end
      default: st_nx = SR_IDLE;
    endcase
  end

endmodule

// File: rtl/ram_datos_dump_ctrl.sv
// Data RAM port owner: CPU pass-through in IDLE, UART dump otherwise.
// Ports: cpu_* CPU side, dump_* dump control, bus = RAM + UART TX.
module ram_datos_dump_ctrl
  import ram_datos_dump_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_w_data,
  output logic [DATA_W-1:0] cpu_r_data,
  output logic              cpu_stall,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_first,
  input  logic [ADDR_W-1:0] dump_last,
  output logic              dump_busy,
  output logic              dump_done,
  ram_datos_dump_ctrl_if.master bus
);

  ctrl_st_t          st, st_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last;
  logic [DATA_W-1:0] word;
  logic              go;
  logic              word_sent;
  logic              start_ok;
  logic              at_last;

  assign start_ok = (st == ST_IDLE) && dump_start;
  assign at_last  = (addr == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_IDLE;
      addr <= '0;
      last <= '0;
      word <= '0;
    end else begin
      st <= st_nx;
      if (start_ok) begin
        addr <= dump_first;
        last <= dump_last;
      end
      if (st == ST_CAP) word <= bus.mem_r_data;
      // Compare before increment: last=max never wraps.
      if (st == ST_NEXT && !at_last) addr <= addr + 1'b1;
    end
  end

  always_comb begin
    st_nx          = st;
    go             = 1'b0;
    dump_done      = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.mem_w_addr = addr;
    bus.mem_r_addr = addr;
    bus.mem_w_data = '0;
    unique case (st)
      ST_IDLE: begin
        bus.mem_wr_en  = cpu_wr_en;
        bus.mem_w_addr = cpu_addr;
        bus.mem_r_addr = cpu_addr;
        bus.mem_w_data = cpu_w_data;
        if (dump_start)
          st_nx = (dump_first > dump_last) ? ST_DONE : ST_RD;
      end
      ST_RD:   st_nx = ST_CAP;
      ST_CAP: begin
        go    = 1'b1;
        st_nx = ST_XFER;
      end
      ST_XFER: begin
        if (word_sent) st_nx = ST_NEXT;
      end
      ST_NEXT: st_nx = at_last ? ST_DONE : ST_RD;
      ST_DONE: begin
        dump_done = 1'b1;
        st_nx     = ST_IDLE;
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  assign cpu_r_data = bus.mem_r_data;
  assign cpu_stall  = (st != ST_IDLE);
  assign dump_busy  = (st != ST_IDLE);

  ram_datos_dump_ctrl_ser u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .word      (word),
    .tx_done   (bus.tx_done),
    .tx_start  (bus.tx_start),
    .tx_data   (bus.tx_data),
    .word_sent (word_sent)
  );

endmodule

// File: tb/tb_ram_datos_dump_ctrl.sv
// Self-checking bench for ram_datos_dump_ctrl.
// RAM and UART TX are modelled here; UART returns tx_done 20 cycles on.
module tb_ram_datos_dump_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_wr_en;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_w_data;
  logic [15:0] cpu_r_data;
  logic        cpu_stall;
  logic        dump_start;
  logic [10:0] dump_first;
  logic [10:0] dump_last;
  logic        dump_busy;
  logic        dump_done;
  logic        spur;
  logic        uart_done;

  int checks;
  int failures;
  int starts;
  int cnt;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] ram [0:2047];

  ram_datos_dump_ctrl_if #(.ADDR_W(11), .DATA_W(16)) bus ();

  ram_datos_dump_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_wr_en  (cpu_wr_en),
    .cpu_addr   (cpu_addr),
    .cpu_w_data (cpu_w_data),
    .cpu_r_data (cpu_r_data),
    .cpu_stall  (cpu_stall),
    .dump_start (dump_start),
    .dump_first (dump_first),
    .dump_last  (dump_last),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // async-read RAM model
  always @(posedge clk)
    if (bus.mem_wr_en) ram[bus.mem_w_addr] <= bus.mem_w_data;
  assign bus.mem_r_data = ram[bus.mem_r_addr];

  // UART model, sampled on the falling edge
  assign uart_done   = (cnt == 1);
  assign bus.tx_done = uart_done | spur;
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt = 0;
    end else if (bus.tx_start) begin
      got_q.push_back(bus.tx_data);
      starts = starts + 1;
      cnt = 20;
    end else if (cnt != 0) begin
      cnt = cnt - 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic run_dump(input logic [10:0] f,
                          input logic [10:0] l,
                          input bit          perturb,
                          input int          exp_busy);
    int c;
    int busy_n, stall_bad, wr_bad, wrap_bad, extra_done;
    bit seen;
    got_q.delete();
    starts = 0;
    busy_n = 0; stall_bad = 0; wr_bad = 0; wrap_bad = 0;
    extra_done = 0; seen = 0; c = 0;
    dump_first = f;
    dump_last  = l;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    while (!seen && c < 3000) begin
      if (perturb) begin
        spur = (c < 2);
        dump_start = (c == 5);
        if (c == 5) begin
          dump_first = 11'd0;
          dump_last  = 11'd0;
        end
        cpu_wr_en  = (c >= 5 && c < 40);
        cpu_addr   = 11'd10;
        cpu_w_data = 16'hDEAD;
        #1;
      end
      if (dump_busy) busy_n++;
      if (!cpu_stall) stall_bad++;
      if (bus.mem_wr_en) wr_bad++;
      if (bus.mem_r_addr < f) wrap_bad++;
      if (dump_done) seen = 1;
      step();
      c++;
    end
    spur = 1'b0; dump_start = 1'b0; cpu_wr_en = 1'b0;
    chk("dump_done_timeout", {31'd0, seen}, 32'd1);
    chk("stall_after", {31'd0, cpu_stall}, 32'd0);
    chk("busy_after", {31'd0, dump_busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (dump_done) extra_done++;
      step();
    end
    chk("dump_done_once", extra_done, 0);
    chk("stall_during", stall_bad, 0);
    chk("wr_en_during", wr_bad, 0);
    chk("addr_range", wrap_bad, 0);
    if (exp_busy >= 0) chk("busy_cycles", busy_n, exp_busy);
    chk("tx_start_count", starts, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("tx_byte%0d", k),
          (k < got_q.size()) ? {24'd0, got_q[k]} : 32'hFFFF,
          {24'd0, exp_q[k]});
  endtask

  initial begin
    int k;
    int dn;
    checks = 0; failures = 0; starts = 0;
    rst_n = 1'b0; spur = 1'b0;
    cpu_wr_en = 1'b0; cpu_addr = '0; cpu_w_data = '0;
    dump_start = 1'b0; dump_first = '0; dump_last = '0;

    vecs = '{
      '{1'b1, 11'd5,    16'hBEEF, 16'h0000},
      '{1'b0, 11'd5,    16'h0000, 16'hBEEF},
      '{1'b1, 11'd10,   16'h1234, 16'h0000},
      '{1'b1, 11'd11,   16'hABCD, 16'h0000},
      '{1'b1, 11'd12,   16'h00FF, 16'h0000},
      '{1'b1, 11'd2046, 16'h5AA5, 16'h0000},
      '{1'b1, 11'd2047, 16'hC33C, 16'h0000},
      '{1'b1, 11'd0,    16'h7777, 16'h0000},
      '{1'b0, 11'd11,   16'h0000, 16'hABCD},
      '{1'b0, 11'd2047, 16'h0000, 16'hC33C}
    };

    step(); step();
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_busy", {31'd0, dump_busy}, 32'd0);
    chk("rst_done", {31'd0, dump_done}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      cpu_wr_en  = vecs[i].we;
      cpu_addr   = vecs[i].addr;
      cpu_w_data = vecs[i].wd;
      #1;
      chk("pt_stall", {31'd0, cpu_stall}, 32'd0);
      chk("pt_wr_en", {31'd0, bus.mem_wr_en}, {31'd0, vecs[i].we});
      chk("pt_r_addr", {21'd0, bus.mem_r_addr}, {21'd0, vecs[i].addr});
      if (vecs[i].we) begin
        chk("pt_w_addr", {21'd0, bus.mem_w_addr}, {21'd0, vecs[i].addr});
        chk("pt_w_data", {16'd0, bus.mem_w_data}, {16'd0, vecs[i].wd});
      end else begin
        chk("pt_r_data", {16'd0, cpu_r_data}, {16'd0, vecs[i].exp_rd});
      end
      step();
    end
    cpu_wr_en = 1'b0;

    // 3 words with spurious done, mid-dump start and CPU writes
    exp_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    run_dump(11'd10, 11'd12, 1'b1, -1);
    cpu_addr = 11'd10;
    #1;
    chk("ram10_kept", {16'd0, cpu_r_data}, 32'h1234);

    // top of the address space
    exp_q = '{8'h5A, 8'hA5, 8'hC3, 8'h3C};
    run_dump(11'd2046, 11'd2047, 1'b0, -1);

    // empty range: only DONE is visited
    exp_q.delete();
    run_dump(11'd8, 11'd7, 1'b0, 1);

    // reset while waiting for the high byte
    got_q.delete();
    starts = 0;
    dump_first = 11'd10; dump_last = 11'd10; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    k = 0;
    while (starts == 0 && k < 50) begin
      step();
      k++;
    end
    chk("rst_test_start_seen", starts, 1);
    step();
    chk("wait_hi_busy", {31'd0, dump_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("mid_rst_busy", {31'd0, dump_busy}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    dn = 0;
    for (int j = 0; j < 5; j++) begin
      if (dump_done || dump_busy) dn++;
      step();
    end
    chk("post_rst_idle", dn, 0);
    cpu_addr = 11'd11;
    #1;
    chk("post_rst_r_data", {16'd0, cpu_r_data}, 32'hABCD);
    chk("post_rst_r_addr", {21'd0, bus.mem_r_addr}, 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
